// File: rtl/slab_interval_reducer.sv
// Reduces three ordered per-axis slab intervals to tnear/tfar via one shared less_than; N*(CMP_LAT+1)+1 cycles accept-to-result.
// Holds the result in DONE until out_ready; in_ready only in IDLE. BEHIND_RAY_CULL_EN adds a 0 < tfar cull comparison.
module slab_interval_reducer #(
  parameter int WIDTH   = 18,
  parameter int CMP_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   near_x,
  input  logic [WIDTH:0]   near_y,
  input  logic [WIDTH:0]   near_z,
  input  logic [WIDTH:0]   far_x,
  input  logic [WIDTH:0]   far_y,
  input  logic [WIDTH:0]   far_z,
  output logic [WIDTH:0]   cmp_a,
  output logic [WIDTH:0]   cmp_b,
  input  logic             cmp_less,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             hit,
  output logic [WIDTH:0]   tnear,
  output logic [WIDTH:0]   tfar
);

  localparam int CW = (CMP_LAT + 1 > 1) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CMP_LAT);
`ifdef BEHIND_RAY_CULL_EN
  localparam int N_CMP = 6;
`else
  localparam int N_CMP = 5;
`endif
  localparam logic [2:0] K_LAST = 3'(N_CMP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]  tnear_q, tnear_d;
  logic [WIDTH:0]  tfar_q, tfar_d;
  logic [WIDTH:0]  near_y_q, near_y_d;
  logic [WIDTH:0]  near_z_q, near_z_d;
  logic [WIDTH:0]  far_y_q, far_y_d;
  logic [WIDTH:0]  far_z_q, far_z_d;
  logic            hit_q, hit_d;
`ifdef BEHIND_RAY_CULL_EN
  logic            hit_cand_q, hit_cand_d;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign hit       = hit_q;
  assign tnear     = tnear_q;
  assign tfar      = tfar_q;

  // Operands come straight from the running min/max, so each step sees earlier updates.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (state_q == S_CMP) begin
      case (k_q)
        3'd0:    begin cmp_a = tnear_q;  cmp_b = near_y_q; end
        3'd1:    begin cmp_a = far_y_q;  cmp_b = tfar_q;   end
        3'd2:    begin cmp_a = tnear_q;  cmp_b = near_z_q; end
        3'd3:    begin cmp_a = far_z_q;  cmp_b = tfar_q;   end
        3'd4:    begin cmp_a = tnear_q;  cmp_b = tfar_q;   end
        default: begin cmp_a = '0;       cmp_b = tfar_q;   end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    tnear_d  = tnear_q;
    tfar_d   = tfar_q;
    near_y_d = near_y_q;
    near_z_d = near_z_q;
    far_y_d  = far_y_q;
    far_z_d  = far_z_q;
    hit_d    = hit_q;
`ifdef BEHIND_RAY_CULL_EN
    hit_cand_d = hit_cand_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tnear_d  = near_x;
          tfar_d   = far_x;
          near_y_d = near_y;
          near_z_d = near_z;
          far_y_d  = far_y;
          far_z_d  = far_z;
          k_d      = 3'd0;
          cnt_d    = '0;
          state_d  = S_CMP;
        end
      end
      S_CMP: begin
        // cmp_less is only trusted on the last cycle of a window.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          k_d   = k_q + 3'd1;
          case (k_q)
            3'd0: if (cmp_less) tnear_d = near_y_q;
            3'd1: if (cmp_less) tfar_d  = far_y_q;
            3'd2: if (cmp_less) tnear_d = near_z_q;
            3'd3: if (cmp_less) tfar_d  = far_z_q;
            3'd4: begin
`ifdef BEHIND_RAY_CULL_EN
              hit_cand_d = cmp_less;
`else
              hit_d = cmp_less;
`endif
            end
`ifdef BEHIND_RAY_CULL_EN
            3'd5: hit_d = hit_cand_q & cmp_less;
`endif
            default: ;
          endcase
          if (k_q == K_LAST) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      tnear_q  <= '0;
      tfar_q   <= '0;
      near_y_q <= '0;
      near_z_q <= '0;
      far_y_q  <= '0;
      far_z_q  <= '0;
      hit_q    <= 1'b0;
`ifdef BEHIND_RAY_CULL_EN
      hit_cand_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      tnear_q  <= tnear_d;
      tfar_q   <= tfar_d;
      near_y_q <= near_y_d;
      near_z_q <= near_z_d;
      far_y_q  <= far_y_d;
      far_z_q  <= far_z_d;
      hit_q    <= hit_d;
`ifdef BEHIND_RAY_CULL_EN
      hit_cand_q <= hit_cand_d;
`endif
    end
  end

endmodule

// File: tb/tb_slab_interval_reducer.sv
// Directed bench for slab_interval_reducer with a behavioural CMP_LAT-deep less_than model.
module tb_slab_interval_reducer;

  localparam int W   = 18;
  localparam int LAT = 3;
`ifdef BEHIND_RAY_CULL_EN
  localparam int N          = 6;
  localparam bit BEHIND_HIT = 1'b0;
`else
  localparam int N          = 5;
  localparam bit BEHIND_HIT = 1'b1;
`endif

  localparam logic [W:0] F_0P5 = 19'h27000;
  localparam logic [W:0] F_1P0 = 19'h27800;
  localparam logic [W:0] F_2P0 = 19'h28000;
  localparam logic [W:0] F_3P0 = 19'h28400;
  localparam logic [W:0] F_M1  = 19'h37800;
  localparam logic [W:0] F_M2  = 19'h38000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   near_x = '0, near_y = '0, near_z = '0;
  logic [W:0]   far_x = '0, far_y = '0, far_z = '0;
  logic [W:0]   cmp_a, cmp_b;
  logic         cmp_less;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         hit;
  logic [W:0]   tnear, tfar;

  int errors = 0;
  int checks = 0;

  slab_interval_reducer #(.WIDTH(W), .CMP_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .near_x(near_x), .near_y(near_y), .near_z(near_z),
    .far_x(far_x), .far_y(far_y), .far_z(far_z),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .tnear(tnear), .tfar(tfar)
  );

  always #5 clk = ~clk;

  // Ordering key: zero maps to 0, positives above it, negatives below it.
  function automatic int fp_key(input logic [W:0] v);
    int m;
    if (v[18:17] == 2'b00) return 0;
    m = int'({16'b0, v[15:0]});
    return v[16] ? -m - 1 : m + 1;
  endfunction

  function automatic logic fp_lt(input logic [W:0] a, input logic [W:0] b);
    return fp_key(a) < fp_key(b);
  endfunction

  logic [LAT-1:0] pipe = '0;
  always @(posedge clk) pipe <= {pipe[LAT-2:0], fp_lt(cmp_a, cmp_b)};
  assign cmp_less = pipe[LAT-1];

  // Caller is #1 after a posedge with the DUT idle; returns snapshots of cycles 1, LAT+2, N(LAT+1), N(LAT+1)+1.
  task automatic run_query(input logic [W:0] nx, fx, ny, fy, nz, fz,
                           output logic [W:0] a1, b1, a5, b5,
                           output logic early, vld, h,
                           output logic [W:0] tn, tf);
    near_x = nx; far_x = fx; near_y = ny; far_y = fy; near_z = nz; far_z = fz;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a1 = cmp_a; b1 = cmp_b;
    repeat (LAT + 1) @(posedge clk); #1;
    a5 = cmp_a; b5 = cmp_b;
    repeat (N * (LAT + 1) - (LAT + 2)) @(posedge clk); #1;
    early = out_valid;
    @(posedge clk); #1;
    vld = out_valid; h = hit; tn = tnear; tf = tfar;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", hit); end
    checks++; if (tnear !== '0) begin errors++; $display("FAIL reset_tnear got=%h want=0", tnear); end
    checks++; if (tfar !== '0) begin errors++; $display("FAIL reset_tfar got=%h want=0", tfar); end
    checks++; if (cmp_a !== '0 || cmp_b !== '0) begin errors++; $display("FAIL reset_cmp got=%h/%h want=0/0", cmp_a, cmp_b); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hit;
    logic [W:0] a1, b1, a5, b5, tn, tf;
    logic early, vld, h;
    run_query(F_0P5, F_3P0, F_1P0, F_2P0, F_0P5, F_2P0, a1, b1, a5, b5, early, vld, h, tn, tf);
    checks++; if (a1 !== F_0P5 || b1 !== F_1P0) begin errors++; $display("FAIL hit_k0_ops got=%h/%h want=%h/%h", a1, b1, F_0P5, F_1P0); end
    checks++; if (a5 !== F_2P0 || b5 !== F_3P0) begin errors++; $display("FAIL hit_k1_ops got=%h/%h want=%h/%h", a5, b5, F_2P0, F_3P0); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL hit_early_valid got=%b want=0", early); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL hit_valid got=%b want=1", vld); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL hit_hit got=%b want=1", h); end
    checks++; if (tn !== F_1P0) begin errors++; $display("FAIL hit_tnear got=%h want=%h", tn, F_1P0); end
    checks++; if (tf !== F_2P0) begin errors++; $display("FAIL hit_tfar got=%h want=%h", tf, F_2P0); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hit_return_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_miss;
    logic [W:0] a1, b1, a5, b5, tn, tf;
    logic early, vld, h;
    run_query(F_0P5, F_1P0, F_2P0, F_3P0, F_0P5, F_3P0, a1, b1, a5, b5, early, vld, h, tn, tf);
    checks++; if (vld !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL miss_hit got vld=%b hit=%b want 1/0", vld, h); end
    checks++; if (tn !== F_2P0 || tf !== F_1P0) begin errors++; $display("FAIL miss_t got=%h/%h want=%h/%h", tn, tf, F_2P0, F_1P0); end
    @(posedge clk); #1;
  endtask

  task automatic test_touch;
    logic [W:0] a1, b1, a5, b5, tn, tf;
    logic early, vld, h;
    run_query(F_1P0, F_2P0, F_0P5, F_1P0, F_0P5, F_2P0, a1, b1, a5, b5, early, vld, h, tn, tf);
    checks++; if (vld !== 1'b1 || h !== 1'b0) begin errors++; $display("FAIL touch_hit got vld=%b hit=%b want 1/0", vld, h); end
    checks++; if (tn !== F_1P0 || tf !== F_1P0) begin errors++; $display("FAIL touch_t got=%h/%h want=%h/%h", tn, tf, F_1P0, F_1P0); end
    @(posedge clk); #1;
  endtask

  task automatic test_behind;
    logic [W:0] a1, b1, a5, b5, tn, tf;
    logic early, vld, h;
    run_query(F_M2, F_M1, F_M2, F_M1, F_M2, F_M1, a1, b1, a5, b5, early, vld, h, tn, tf);
    checks++; if (early !== 1'b0 || vld !== 1'b1) begin errors++; $display("FAIL behind_valid got early=%b vld=%b want 0/1", early, vld); end
    checks++; if (h !== BEHIND_HIT) begin errors++; $display("FAIL behind_hit got=%b want=%b", h, BEHIND_HIT); end
    checks++; if (tn !== F_M2 || tf !== F_M1) begin errors++; $display("FAIL behind_t got=%h/%h want=%h/%h", tn, tf, F_M2, F_M1); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [W:0] a1, b1, a5, b5, tn, tf;
    logic early, vld, h;
    int bad;
    out_ready = 1'b0;
    run_query(F_0P5, F_3P0, F_1P0, F_2P0, F_0P5, F_2P0, a1, b1, a5, b5, early, vld, h, tn, tf);
    checks++; if (vld !== 1'b1 || h !== 1'b1) begin errors++; $display("FAIL bp_first got vld=%b hit=%b want 1/1", vld, h); end
    near_x = F_0P5; far_x = F_1P0; near_y = F_2P0; far_y = F_3P0; near_z = F_0P5; far_z = F_3P0;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || hit !== 1'b1 || tnear !== F_1P0 || tfar !== F_2P0 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0 (last vld=%b hit=%b tn=%h tf=%h rdy=%b)", bad, out_valid, hit, tnear, tfar, in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept got rdy=%b want=1", in_ready); end
  endtask

  task automatic test_reset_abort;
    logic [W:0] a1, b1, a5, b5, tn, tf;
    logic early, vld, h;
    int seen;
    near_x = F_0P5; far_x = F_3P0; near_y = F_1P0; far_y = F_2P0; near_z = F_0P5; far_z = F_2P0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_state got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    checks++; if (tnear !== '0 || tfar !== '0 || cmp_a !== '0) begin errors++; $display("FAIL abort_regs got tn=%h tf=%h a=%h want 0", tnear, tfar, cmp_a); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen); end
    run_query(F_0P5, F_3P0, F_1P0, F_2P0, F_0P5, F_2P0, a1, b1, a5, b5, early, vld, h, tn, tf);
    checks++; if (early !== 1'b0 || vld !== 1'b1) begin errors++; $display("FAIL abort_next_valid got early=%b vld=%b want 0/1", early, vld); end
    checks++; if (h !== 1'b1 || tn !== F_1P0 || tf !== F_2P0) begin errors++; $display("FAIL abort_next_result got hit=%b tn=%h tf=%h want 1/%h/%h", h, tn, tf, F_1P0, F_2P0); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_hit;
    test_miss;
    test_touch;
    test_behind;
    test_backpressure;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slab_interval_reducer.md
Name: slab_interval_reducer

Overview:
- Sits directly upstream of the less_than comparator in the Ray-AABB datapath and consumes its registered `less` bit.
- Accepts one ray/box query: three per-axis slab intervals, each already ordered (near <= far), as FloPoCo 11_5 values.
- Drives a single shared less_than instance sequentially to reduce them to tnear = max(near), tfar = min(far), then decides hit.
- Non-pipelined: one query in flight at a time.

Parameters:
- WIDTH, 18: MSB index of FP words; words are [WIDTH:0], 19 bits = exn[18:17], sign[16], exp[15:11], frac[10:0].
- CMP_LAT, 3: cycles from operands first presented on cmp_a/cmp_b to valid cmp_less; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  query valid.
- in_ready  out  1  block idle, can accept a query.
- near_x, near_y, near_z  in  WIDTH+1  per-axis entry t.
- far_x, far_y, far_z  in  WIDTH+1  per-axis exit t.
- cmp_a  out  WIDTH+1  operand A to less_than (inA).
- cmp_b  out  WIDTH+1  operand B to less_than (inB).
- cmp_less  in  1  less_than result: 1 iff A-B is a normal negative number (strict A < B).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- hit  out  1  ray intersects box.
- tnear  out  WIDTH+1  reduced entry t.
- tfar  out  WIDTH+1  reduced exit t.

Behaviour:
- Reset (rst high at a clock edge) gives: state IDLE; in_ready=1; out_valid=0; hit=0; tnear=0; tfar=0; cmp_a=0; cmp_b=0; wait counter=0.
- States: IDLE -> CMP -> DONE -> IDLE.
- IDLE: in_ready=1. An accept (in_valid & in_ready) captures all six inputs, sets tnear=near_x, tfar=far_x, sets comparison index k=0, and moves to CMP. in_ready drops the next cycle.
- CMP: comparison k holds cmp_a/cmp_b constant for CMP_LAT+1 cycles. Inputs are ignored while in CMP.
- Windows: with the accept at cycle 0, comparison k drives operands during cycles 1+k(CMP_LAT+1) .. (k+1)(CMP_LAT+1). cmp_less is sampled only on the last cycle of each window. The new operands appear on the cycle after sampling.
- Comparison sequence (A, B -> action if less=1):
  - k0: tnear, near_y -> tnear=near_y
  - k1: far_y, tfar -> tfar=far_y
  - k2: tnear, near_z -> tnear=near_z
  - k3: far_z, tfar -> tfar=far_z
  - k4: tnear, tfar -> hit_candidate=less
- The operands of k1..k4 use the values updated by earlier comparisons.
- After the last sample, go to DONE. Default N=5, so out_valid rises at cycle N(CMP_LAT+1)+1, i.e. 21 with CMP_LAT=3.
- DONE: out_valid=1. hit, tnear and tfar stay stable until out_valid & out_ready, then return to IDLE (in_ready=1 the following cycle).
- Simultaneous out handshake and a new in_valid: the query is not accepted until the IDLE cycle.
- Equality: tnear == tfar gives less=0, so hit=0 (strict). NaN/Inf operands: the cmp_less value is taken as-is, with no special casing.
- rst asserted in any state, including mid-CMP, aborts the query immediately. Outputs take reset values and no out_valid is produced for the aborted query. cmp_less values still in flight after reset are ignored, because sampling only occurs in CMP windows.
- Wait counter: width ceil(log2(CMP_LAT+1)); it resets to 0 at the start of every window.

Optional Feature:
- Macro: BEHIND_RAY_CULL_EN.
- Defined: adds k5, comparing A=0 (all-zero word, exn=00) with B=tfar; hit = hit_candidate & less. N=6, so out_valid rises at cycle 6(CMP_LAT+1)+1 = 25 with CMP_LAT=3. Boxes entirely behind the origin, or with tfar==0, are rejected.
- Undefined: hit = hit_candidate; N=5.

Test Plan:
- FP encodings used: 0.5=0x27000, 1.0=0x27800, 2.0=0x28000, 3.0=0x28400, -1.0=0x37800, -2.0=0x38000. CMP_LAT=3 and a behavioural less_than model throughout.
- Hit: x[0.5,3.0], y[1.0,2.0], z[0.5,2.0] -> out_valid at cycle 21 (25 with macro), hit=1, tnear=0x27800, tfar=0x28000.
- Miss: x[0.5,1.0], y[2.0,3.0], z[0.5,3.0] -> hit=0, tnear=0x28000, tfar=0x27800.
- Touch: x[1.0,2.0], y[0.5,1.0], z[0.5,2.0] -> tnear=tfar=0x27800, hit=0.
- Behind: all axes [-2.0,-1.0] -> tnear=0x38000, tfar=0x37800; hit=1 at cycle 21 without macro, hit=0 at cycle 25 with macro.
- Backpressure and reset:
  - Hit query with out_ready low for 10 cycles after out_valid -> outputs stable, in_ready=0, second in_valid ignored. Raising out_ready completes the handshake; in_ready=1 on the next cycle.
  - rst pulsed at cycle 7 of a query -> out_valid never asserts for it, in_ready=1 after reset. The next Hit query returns correct results at its own cycle 21.
